reg_write_demux_file: RTL and testbench
=======================================

// Module: reg_write_demux_file
// PURPOSE
//   Write-side consumer of the 5-bit destination-register select path: demultiplexes the
//   selected 5-bit write address into 32 one-hot write strobes and stores data in a
//   32 x DATA_W register bank. Provides two asynchronous read ports for the
//   single-cycle datapath. Sits between the destination-register mux / write-back
//   mux and the ALU operand inputs.
// PARAMETERS
//   DATA_W   32  width of each register and of the write/read data buses
//   ADDR_W    5  address width; bank depth is 2**ADDR_W (fixed at 32 entries)
// PORTS
//   clk       in   1       rising-edge clock, the only clock
//   reset     in   1       synchronous, active-high reset
//   wr_en     in   1       RegWrite control; a write occurs only when high
//   wr_addr   in   ADDR_W  destination register (output of the 5-bit select mux)
//   wr_data   in   DATA_W  write-back data
//   rd_addr_a in   ADDR_W  read port A address (rs)
//   rd_addr_b in   ADDR_W  read port B address (rt)
//   rd_data_a out  DATA_W  read port A data
//   rd_data_b out  DATA_W  read port B data
//   wr_strobe out  32      registered one-hot copy of last cycle's effective write strobe
// BEHAVIOUR
//   - Decode: strobe[i] = wr_en & (wr_addr == i), for i = 1..31; strobe[0] is always 0.
//   - Write: on a rising clk edge with reset low, reg[i] <= wr_data where strobe[i] = 1.
//     Exactly one entry changes per write; all others hold.
//   - Register 0 is hardwired to zero: writes to address 0 are discarded and do not
//     raise wr_strobe; reads of address 0 return 0.
//   - Reads are combinational (zero-cycle latency): rd_data_x = reg[rd_addr_x].
//     Both ports may read the same address at the same time.
//   - Read-during-write to the same address (without the macro): the read returns the
//     OLD value until the clock edge, then the new value.
//   - wr_strobe <= strobe on each edge (1-cycle latency). Use: write-back observability.
//   - Reset (synchronous): on a clk edge with reset high, all 32 registers <= 0 and
//     wr_strobe <= 0. Reset takes priority over a write in the same cycle, and the write
//     is lost. After reset, both rd_data ports read 0 for every address.
//   - X/Z on wr_addr while wr_en = 0 must not corrupt any entry.
//   - There is no state machine. State = 31 data registers plus the wr_strobe register.
// CONFIGURATION
//   WRITE_BYPASS_EN  when defined: if wr_en = 1, wr_addr != 0 and
//     rd_addr_x == wr_addr, then rd_data_x = wr_data in the same cycle (write-first
//     forwarding, combinational). Storage timing is unchanged.
//     When undefined: there is no forwarding, and reads return the stored value only.
// TESTING
//   1. Assert reset for 1 cycle with wr_en = 1, wr_addr = 5, wr_data = 32'hFFFF_FFFF.
//      -> reg5 reads 0 and wr_strobe = 0.
//   2. Write 32'hDEAD_BEEF to addr 31 and 32'h1 to addr 1, then read A = 31, B = 1.
//      -> A = DEAD_BEEF and B = 1. wr_strobe = 32'h8000_0000, then 32'h0000_0002.
//   3. Write 32'h1234 to addr 0. -> rd_data_a(0) = 0 and wr_strobe = 0. No other
//      register changes.
//   4. With wr_en = 0, wr_addr = 7 and wr_data = 32'hAAAA, clock 3 cycles.
//      -> reg7 keeps its prior value and wr_strobe = 0.
//   5. Set reg9 = 32'h5. In the same cycle, write 32'h6 to addr 9 with rd_addr_a = 9.
//      -> Before the edge, rd_data_a = 5 (no macro) or 6 (WRITE_BYPASS_EN).
//         After the edge, rd_data_a = 6 in both builds.
//   6. Fill all 31 writable registers with value = index, then pulse reset mid-sequence.
//      -> All 32 addresses read 0 on both ports, and the following write to addr 3
//         succeeds normally.

Source files
------------

// File: rtl/reg_write_demux_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_demux_file
// Purpose  : Write-side register bank for the single-cycle datapath. Decodes
//            the 5-bit destination-register address into 32 one-hot write
//            strobes, stores write-back data in a 32 x DATA_W bank
//            (register 0 hardwired to zero) and serves two combinational
//            read ports (rs / rt).
// Ports    : clk_i          rising-edge clock
//            reset_i        synchronous active-high reset (clears bank + strobe)
//            wr_en_i        RegWrite; a write happens only when high
//            wr_addr_i      destination register address
//            wr_data_i      write-back data
//            rd_addr_a_i    read port A address
//            rd_addr_b_i    read port B address
//            rd_data_a_o    read port A data (zero-cycle latency)
//            rd_data_b_o    read port B data (zero-cycle latency)
//            wr_strobe_o    registered copy of last cycle's effective strobe
// Options  : WRITE_BYPASS_EN - when defined, a read whose address matches an
//            active non-zero write address returns wr_data_i in the same
//            cycle (write-first forwarding). Default build: no forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_demux_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  output logic [31:0]       wr_strobe_o
);

  localparam int C_DEPTH = 1 << ADDR_W;

  // Effective one-hot write strobe for the current cycle.
  logic [C_DEPTH-1:0] strobe_d;
  logic [C_DEPTH-1:0] wr_strobe_q;

  // Storage exists only for the writable entries 1..DEPTH-1.
  logic [DATA_W-1:0] regs_q [1:C_DEPTH-1];

  // Read view of the whole bank, entry 0 tied to zero.
  logic [DATA_W-1:0] rf_w [C_DEPTH];

  // Entry 0 never strobes, so writes to address 0 are silently discarded.
  assign strobe_d[0] = 1'b0;
  assign rf_w[0]     = '0;

  generate
    for (genvar i = 1; i < C_DEPTH; i++) begin : g_entry
      // Gating with wr_en_i first keeps an unknown address harmless while
      // the write enable is low.
      assign strobe_d[i] = wr_en_i && (wr_addr_i == ADDR_W'(i));
      assign rf_w[i]     = regs_q[i];

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          regs_q[i] <= '0;
        end else if (strobe_d[i]) begin
          regs_q[i] <= wr_data_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_strobe_q <= '0;
    end else begin
      wr_strobe_q <= strobe_d;
    end
  end

  assign wr_strobe_o = wr_strobe_q;

`ifdef WRITE_BYPASS_EN
  // Write-first forwarding: a matching active write overrides the stored
  // value combinationally; address 0 is excluded so it still reads zero.
  logic fwd_a_w;
  logic fwd_b_w;

  assign fwd_a_w = wr_en_i && (wr_addr_i != '0) && (rd_addr_a_i == wr_addr_i);
  assign fwd_b_w = wr_en_i && (wr_addr_i != '0) && (rd_addr_b_i == wr_addr_i);

  assign rd_data_a_o = fwd_a_w ? wr_data_i : rf_w[rd_addr_a_i];
  assign rd_data_b_o = fwd_b_w ? wr_data_i : rf_w[rd_addr_b_i];
`else
  // Reads return stored contents only; a same-cycle write shows up after
  // the clock edge.
  assign rd_data_a_o = rf_w[rd_addr_a_i];
  assign rd_data_b_o = rf_w[rd_addr_b_i];
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_write_demux_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_demux_file
// Purpose  : Directed self-checking bench for reg_write_demux_file: reset,
//            write/read, address-0 discard, write-disable hold, read-during-
//            write (both build options) and reset in the middle of a fill.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_demux_file;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] wr_strobe;

  int n_cmp = 0;
  int n_err = 0;

  // Expected bank contents, maintained by hand alongside the stimulus.
  logic [31:0] exp_rf [32];

  reg_write_demux_file #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .rd_data_a_o (rd_data_a),
    .rd_data_b_o (rd_data_b),
    .wr_strobe_o (wr_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    if (a != 5'd0) exp_rf[a] = d;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hFFFF_FFFF;
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
    rd_addr_a = 5'd5;
    rd_addr_b = 5'd5;
    #1;
    n_cmp++;
    if (rd_data_a !== 32'h0) begin
      n_err++;
      $display("FAIL reset_reg5_a: got %h want %h", rd_data_a, 32'h0);
    end
    n_cmp++;
    if (wr_strobe !== 32'h0) begin
      n_err++;
      $display("FAIL reset_strobe: got %h want %h", wr_strobe, 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      n_cmp++;
      if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
        n_err++;
        $display("FAIL reset_all_zero[%0d]: got a=%h b=%h want 0", i, rd_data_a, rd_data_b);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(5'd31, 32'hDEAD_BEEF);
    n_cmp++;
    if (wr_strobe !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL strobe_addr31: got %h want %h", wr_strobe, 32'h8000_0000);
    end
    do_write(5'd1, 32'h0000_0001);
    n_cmp++;
    if (wr_strobe !== 32'h0000_0002) begin
      n_err++;
      $display("FAIL strobe_addr1: got %h want %h", wr_strobe, 32'h0000_0002);
    end
    tick();
    n_cmp++;
    if (wr_strobe !== 32'h0) begin
      n_err++;
      $display("FAIL strobe_idle: got %h want %h", wr_strobe, 32'h0);
    end
    rd_addr_a = 5'd31;
    rd_addr_b = 5'd1;
    #1;
    n_cmp++;
    if (rd_data_a !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL read_a31: got %h want %h", rd_data_a, 32'hDEAD_BEEF);
    end
    n_cmp++;
    if (rd_data_b !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL read_b1: got %h want %h", rd_data_b, 32'h0000_0001);
    end
    // Both ports reading the same address.
    rd_addr_b = 5'd31;
    #1;
    n_cmp++;
    if (rd_data_b !== 32'hDEAD_BEEF || rd_data_a !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL read_same_addr: got a=%h b=%h want %h", rd_data_a, rd_data_b, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_addr_zero();
    do_write(5'd0, 32'h0000_1234);
    n_cmp++;
    if (wr_strobe !== 32'h0) begin
      n_err++;
      $display("FAIL addr0_strobe: got %h want %h", wr_strobe, 32'h0);
    end
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    #1;
    n_cmp++;
    if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
      n_err++;
      $display("FAIL addr0_read: got a=%h b=%h want 0", rd_data_a, rd_data_b);
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      #1;
      n_cmp++;
      if (rd_data_a !== exp_rf[i]) begin
        n_err++;
        $display("FAIL addr0_others[%0d]: got %h want %h", i, rd_data_a, exp_rf[i]);
      end
    end
  endtask

  task automatic test_wr_disabled();
    do_write(5'd7, 32'h0000_0077);
    wr_en     = 1'b0;
    wr_addr   = 5'd7;
    wr_data   = 32'h0000_AAAA;
    rd_addr_a = 5'd7;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (wr_strobe !== 32'h0 || rd_data_a !== 32'h0000_0077) begin
        n_err++;
        $display("FAIL wr_disabled[%0d]: got reg7=%h strobe=%h want reg7=%h strobe=0",
                 c, rd_data_a, wr_strobe, 32'h0000_0077);
      end
    end
    // Unknown address with the write disabled must leave every entry intact.
    wr_addr = 5'bxxxxx;
    tick();
    tick();
    wr_addr = 5'd0;
    for (int i = 0; i < 32; i++) begin
      rd_addr_b = 5'(i);
      #1;
      n_cmp++;
      if (rd_data_b !== exp_rf[i]) begin
        n_err++;
        $display("FAIL x_addr_hold[%0d]: got %h want %h", i, rd_data_b, exp_rf[i]);
      end
    end
    n_cmp++;
    if (wr_strobe !== 32'h0) begin
      n_err++;
      $display("FAIL x_addr_strobe: got %h want %h", wr_strobe, 32'h0);
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] pre_exp;
`ifdef WRITE_BYPASS_EN
    pre_exp = 32'h6;
`else
    pre_exp = 32'h5;
`endif
    do_write(5'd9, 32'h5);
    wr_en     = 1'b1;
    wr_addr   = 5'd9;
    wr_data   = 32'h6;
    rd_addr_a = 5'd9;
    rd_addr_b = 5'd9;
    #1;
    n_cmp++;
    if (rd_data_a !== pre_exp || rd_data_b !== pre_exp) begin
      n_err++;
      $display("FAIL rdw_before_edge: got a=%h b=%h want %h", rd_data_a, rd_data_b, pre_exp);
    end
    tick();
    wr_en = 1'b0;
    exp_rf[9] = 32'h6;
    #1;
    n_cmp++;
    if (rd_data_a !== 32'h6) begin
      n_err++;
      $display("FAIL rdw_after_edge: got %h want %h", rd_data_a, 32'h6);
    end
    n_cmp++;
    if (wr_strobe !== 32'h0000_0200) begin
      n_err++;
      $display("FAIL rdw_strobe: got %h want %h", wr_strobe, 32'h0000_0200);
    end
  endtask

  task automatic test_fill_and_reset();
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      #1;
      n_cmp++;
      if (rd_data_a !== 32'(i)) begin
        n_err++;
        $display("FAIL fill[%0d]: got %h want %h", i, rd_data_a, 32'(i));
      end
    end
    // Reset pulse concurrent with a write: the write must be lost.
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd12;
    wr_data = 32'hCAFE_0000;
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(i);
      #1;
      n_cmp++;
      if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
        n_err++;
        $display("FAIL fill_reset[%0d]: got a=%h b=%h want 0", i, rd_data_a, rd_data_b);
      end
    end
    n_cmp++;
    if (wr_strobe !== 32'h0) begin
      n_err++;
      $display("FAIL fill_reset_strobe: got %h want %h", wr_strobe, 32'h0);
    end
    do_write(5'd3, 32'h0000_0033);
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd4;
    #1;
    n_cmp++;
    if (rd_data_a !== 32'h33 || rd_data_b !== 32'h0 || wr_strobe !== 32'h0000_0008) begin
      n_err++;
      $display("FAIL post_reset_write: got a=%h b=%h strobe=%h want 33/0/00000008",
               rd_data_a, rd_data_b, wr_strobe);
    end
  endtask

  initial begin
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = 5'd0;
    wr_data   = 32'h0;
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    tick();
    test_reset();
    test_write_read();
    test_addr_zero();
    test_wr_disabled();
    test_read_during_write();
    test_fill_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
